csi2tx_p2b_ctrl: RTL
====================

CSI2TX_P2B_CTRL -- requirements
Module: csi2tx_p2b_ctrl

Interface
REQ-001 SHALL: clk  in  1  core clock; all logic on rising edge.
REQ-002 SHALL: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: ctrl_en  in  1  block enable; low forces abort to IDLE.
REQ-004 SHALL: data_type  in  6  CSI-2 data type; RAW8=0x2A, RAW10=0x2B, RAW12=0x2C.
REQ-005 SHALL: sensor_pixel_vld  in  1  sensor line-valid/pixel-valid qualifier.
REQ-006 SHALL: sensor_pixel_data  in  12  sensor pixel, LSB-justified.
REQ-007 SHALL: pixel_data  out  12  registered pixel to converters.
REQ-008 SHALL: pixel_data_vld  out  1  registered pixel qualifier.
REQ-009 SHALL: pixel_cnt  out  4  pixel index within packing group, aligned to pixel_data.
REQ-010 SHALL: sensor_pixel_vld_falling_edge  out  1  one-cycle end-of-line pulse.
REQ-011 SHALL: raw8_convrn_enable, raw10_convrn_enable, raw12_convrn_enable  out  1 each  one-hot converter enables.
REQ-012 SHALL: line_byte_cnt  out  16  packed byte count of last line; valid with line_done.
REQ-013 SHALL: line_done  out  1  one-cycle line-complete pulse.
REQ-014 SHALL: dt_err  out  1  one-cycle pulse, unsupported data_type at line start.
REQ-015 SHALL: ovr_err  out  1  one-cycle pulse, sensor_pixel_vld high during FLUSH/DONE.

Function
REQ-016 SHALL: FSM states IDLE, ACTIVE, FLUSH, DONE, SKIP; all transitions gated by ctrl_en=1.
REQ-017 SHALL: IDLE->ACTIVE on sensor_pixel_vld=1 with supported data_type; data_type latched that cycle, held to end of line; changes mid-line ignored.
REQ-018 SHALL: IDLE->SKIP on sensor_pixel_vld=1 with unsupported data_type; dt_err pulses next cycle; all pixels dropped, no enables; SKIP->IDLE when sensor_pixel_vld=0; no line_done.
REQ-019 SHALL: in ACTIVE, pixel_data/pixel_data_vld = sensor inputs delayed exactly 1 cycle; the enable of the latched type asserts from the first pixel_data_vld.
REQ-020 SHALL: pixel_cnt starts 0 on first pixel, increments per valid output pixel, wrap modulus RAW8=4, RAW10=16, RAW12=8; holds when pixel_data_vld=0 mid-line.
REQ-021 SHALL: ACTIVE->FLUSH on sensor_pixel_vld 1->0; in FLUSH, falling_edge=1 for exactly one cycle, pixel_data_vld=0, pixel_cnt = line pixels mod modulus (nonzero = partial group).
REQ-022 SHALL: FLUSH->DONE unconditionally; in DONE line_done=1 one cycle, line_byte_cnt updated, pixel_cnt=0; DONE->IDLE.
REQ-023 SHALL: converter enable stays high through FLUSH and DONE, drops entering IDLE.
REQ-024 SHALL: line pixel counter 14 bits, saturating at 16383.
REQ-025 SHALL: line_byte_cnt = N (RAW8), ceil(5N/4) (RAW10), ceil(3N/2) (RAW12), N = line pixels; held until next line_done.
REQ-026 SHALL: sensor_pixel_vld=1 in FLUSH or DONE -> ovr_err pulse, those pixels dropped, line completes normally, FSM to SKIP if vld still high at exit of DONE.
REQ-027 SHALL: ctrl_en=0 in any state -> next cycle IDLE, all enables/vld/pulses 0, pixel_cnt=0, no line_done; line_byte_cnt retained.
REQ-028 SHALL: ctrl_en rising while sensor_pixel_vld=1 -> SKIP (no partial line captured).

Reset
REQ-029 SHALL: on rst_n=0 asynchronously: FSM=IDLE, all outputs 0, latched data_type 0, line_byte_cnt 0.
REQ-030 SHALL: first line after rst_n release processed normally if it starts in IDLE with vld low first.

Verification
REQ-031 SHALL: RAW10, 16-pixel line -> pixel_cnt 0..15, FLUSH pixel_cnt=0, line_done with line_byte_cnt=20.
REQ-032 SHALL: RAW10, 6-pixel line -> falling_edge with pixel_cnt=6, enable high through DONE, line_byte_cnt=8.
REQ-033 SHALL: RAW12, 5 pixels -> pixel_cnt 0..4, FLUSH pixel_cnt=5, line_byte_cnt=8; RAW8 7 pixels -> line_byte_cnt=7.
REQ-034 SHALL: data_type=0x30 at line start -> dt_err single pulse, no enable, no pixel_data_vld, no line_done.
REQ-035 SHALL: sensor_pixel_vld re-asserted 1 cycle after drop -> ovr_err, prior line_done still issued, new line skipped.
REQ-036 SHALL: rst_n low mid-line (pixel 9, RAW10) -> all outputs 0 immediately; ctrl_en low mid-line -> IDLE next cycle, no line_done.

Source files
------------

// File: rtl/csi2tx_p2b_ctrl.sv
// Pixel-to-byte packing controller for a CSI-2 transmitter: qualifies sensor
// pixels per line, tracks packing-group position and reports the packed byte count.
module csi2tx_p2b_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_en,
  input  logic [5:0]  data_type,
  input  logic        sensor_pixel_vld,
  input  logic [11:0] sensor_pixel_data,
  output logic [11:0] pixel_data,
  output logic        pixel_data_vld,
  output logic [3:0]  pixel_cnt,
  output logic        sensor_pixel_vld_falling_edge,
  output logic        raw8_convrn_enable,
  output logic        raw10_convrn_enable,
  output logic        raw12_convrn_enable,
  output logic [15:0] line_byte_cnt,
  output logic        line_done,
  output logic        dt_err,
  output logic        ovr_err
);

  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;
  localparam logic [5:0] DT_RAW12 = 6'h2C;

  typedef enum logic [2:0] {IDLE, ACTIVE, FLUSH, DONE, SKIP} state_t;

  state_t      state;
  logic [5:0]  dt_lat;
  logic [13:0] line_pix;
  logic        en_prev;
  logic        ovr_seen;
  logic        dt_ok;
  logic [3:0]  cnt_mask;
  logic [15:0] n16;
  logic [15:0] bytes_next;

  always_comb begin
    dt_ok = (data_type == DT_RAW8) || (data_type == DT_RAW10) || (data_type == DT_RAW12);
    n16   = {2'b00, line_pix};
    case (dt_lat)
      DT_RAW8:  begin cnt_mask = 4'd3;  bytes_next = n16; end
      DT_RAW10: begin cnt_mask = 4'd15; bytes_next = n16 + ((n16 + 16'd3) >> 2); end
      DT_RAW12: begin cnt_mask = 4'd7;  bytes_next = n16 + ((n16 + 16'd1) >> 1); end
      default:  begin cnt_mask = 4'd15; bytes_next = n16; end
    endcase
  end

  // A line only starts if ctrl_en was already high the cycle before, so a
  // line already in progress when the block is enabled is skipped whole.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                         <= IDLE;
      dt_lat                        <= 6'd0;
      line_pix                      <= 14'd0;
      en_prev                       <= 1'b0;
      ovr_seen                      <= 1'b0;
      pixel_data                    <= 12'd0;
      pixel_data_vld                <= 1'b0;
      pixel_cnt                     <= 4'd0;
      sensor_pixel_vld_falling_edge <= 1'b0;
      raw8_convrn_enable            <= 1'b0;
      raw10_convrn_enable           <= 1'b0;
      raw12_convrn_enable           <= 1'b0;
      line_byte_cnt                 <= 16'd0;
      line_done                     <= 1'b0;
      dt_err                        <= 1'b0;
      ovr_err                       <= 1'b0;
    end else begin
      en_prev                       <= ctrl_en;
      pixel_data_vld                <= 1'b0;
      sensor_pixel_vld_falling_edge <= 1'b0;
      line_done                     <= 1'b0;
      dt_err                        <= 1'b0;
      ovr_err                       <= 1'b0;
      if (!ctrl_en) begin
        state               <= IDLE;
        pixel_cnt           <= 4'd0;
        raw8_convrn_enable  <= 1'b0;
        raw10_convrn_enable <= 1'b0;
        raw12_convrn_enable <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sensor_pixel_vld) begin
              if (!en_prev) begin
                state <= SKIP;
              end else if (dt_ok) begin
                state               <= ACTIVE;
                dt_lat              <= data_type;
                raw8_convrn_enable  <= (data_type == DT_RAW8);
                raw10_convrn_enable <= (data_type == DT_RAW10);
                raw12_convrn_enable <= (data_type == DT_RAW12);
                pixel_data          <= sensor_pixel_data;
                pixel_data_vld      <= 1'b1;
                pixel_cnt           <= 4'd0;
                line_pix            <= 14'd1;
                ovr_seen            <= 1'b0;
              end else begin
                state  <= SKIP;
                dt_err <= 1'b1;
              end
            end
          end
          ACTIVE: begin
            if (sensor_pixel_vld) begin
              pixel_data     <= sensor_pixel_data;
              pixel_data_vld <= 1'b1;
              pixel_cnt      <= (pixel_cnt + 4'd1) & cnt_mask;
              if (line_pix != 14'h3FFF)
                line_pix <= line_pix + 14'd1;
            end else begin
              state                         <= FLUSH;
              sensor_pixel_vld_falling_edge <= 1'b1;
              pixel_cnt                     <= line_pix[3:0] & cnt_mask;
            end
          end
          FLUSH: begin
            state         <= DONE;
            line_done     <= 1'b1;
            line_byte_cnt <= bytes_next;
            pixel_cnt     <= 4'd0;
            if (sensor_pixel_vld) begin
              ovr_err  <= 1'b1;
              ovr_seen <= 1'b1;
            end
          end
          DONE: begin
            raw8_convrn_enable  <= 1'b0;
            raw10_convrn_enable <= 1'b0;
            raw12_convrn_enable <= 1'b0;
            if (sensor_pixel_vld) begin
              state <= SKIP;
              if (!ovr_seen)
                ovr_err <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          SKIP: begin
            if (!sensor_pixel_vld)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
